// File: rtl/irrigation_zone_controller.sv
// Multi-zone irrigation controller: shared tank level, zone grant, low-level refill pause/resume,
// post-fertiliser flush and sticky supply fault. Define RR_ARB_EN for round-robin zone grant.
module irrigation_zone_controller #(
    parameter int NUM_ZONES    = 4,
    parameter int LEVEL_W      = 3,
    parameter int LEVEL_MAX    = 7,
    parameter int LEVEL_LOW    = 2,
    parameter int CLEAN_TICKS  = 3,
    parameter int FILL_TIMEOUT = 4,
    localparam int AZW         = $clog2(NUM_ZONES)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 tick_i,
    input  logic [NUM_ZONES-1:0] zone_req_i,
    input  logic [NUM_ZONES-1:0] zone_mode_i,
    input  logic                 adb_i,
    input  logic                 supply_ok_i,
    output logic                 valve_in_o,
    output logic [NUM_ZONES-1:0] zone_valve_o,
    output logic [LEVEL_W-1:0]   level_o,
    output logic [AZW-1:0]       active_zone_o,
    output logic                 cleaning_o,
    output logic                 erro_o,
    output logic [2:0]           state_o
);

    localparam int CW = $clog2(CLEAN_TICKS + 1);
    localparam int TW = $clog2(FILL_TIMEOUT + 1);
    localparam logic [LEVEL_W-1:0] LVL_MAX = LEVEL_W'(LEVEL_MAX);
    localparam logic [LEVEL_W-1:0] LVL_LOW = LEVEL_W'(LEVEL_LOW);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_IRR   = 3'd2,
        S_CLEAN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [LEVEL_W-1:0]     level_q, level_d;
    logic [AZW-1:0]         active_q, active_d;
    logic                   fert_q, fert_d;
    logic                   drip_q, drip_d;
    logic                   phase_q, phase_d;
    logic                   paused_q, paused_d;
    logic [CW-1:0]          clean_cnt_q, clean_cnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   valve_in_q, valve_in_d;
    logic [NUM_ZONES-1:0]   zone_valve_q, zone_valve_d;
    logic                   cleaning_q, cleaning_d;
    logic                   erro_q, erro_d;
`ifdef RR_ARB_EN
    logic [AZW-1:0]         last_q, last_d;
`endif

    logic [AZW-1:0]         grant;
    logic [TW-1:0]          timer_step;
    logic                   fault;
    logic                   fill_up;

    // First requesting zone found scanning upward (with wrap) from start.
    function automatic logic [AZW-1:0] pick(input logic [NUM_ZONES-1:0] req, input logic [AZW-1:0] start);
        logic [AZW-1:0] g;
        logic           found;
        int             idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            idx = (int'(start) + i) % NUM_ZONES;
            if (!found && req[idx]) begin
                g     = AZW'(idx);
                found = 1'b1;
            end
        end
        return g;
    endfunction

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        active_d    = active_q;
        fert_d      = fert_q;
        drip_d      = drip_q;
        phase_d     = phase_q;
        paused_d    = paused_q;
        clean_cnt_d = clean_cnt_q;
        timer_d     = timer_q;
`ifdef RR_ARB_EN
        last_d      = last_q;
        grant       = pick(zone_req_i, AZW'((int'(last_q) + 1) % NUM_ZONES));
`else
        grant       = pick(zone_req_i, '0);
`endif
        timer_step  = timer_q + TW'(1);
        fault       = 1'b0;
        fill_up     = tick_i && valve_in_q && supply_ok_i && (level_q < LVL_MAX) &&
                      (state_q == S_IDLE || state_q == S_FILL);

        if (tick_i && state_q != S_ERR) begin
            if (valve_in_q && !supply_ok_i) begin
                timer_d = timer_step;
                fault   = (timer_step == TW'(FILL_TIMEOUT));
            end else begin
                timer_d = '0;
            end
        end

        if (fault) begin
            state_d = S_ERR;
        end else begin
            if (fill_up)
                level_d = level_q + LEVEL_W'(1);
            case (state_q)
                S_IDLE: begin
                    if (|zone_req_i) begin
                        if (level_q > LVL_LOW) begin
                            state_d  = S_IRR;
                            active_d = grant;
                            fert_d   = adb_i;
                            drip_d   = !zone_mode_i[grant];
                            phase_d  = 1'b0;
`ifdef RR_ARB_EN
                            last_d   = grant;
`endif
                        end else begin
                            state_d  = S_FILL;
                            paused_d = 1'b0;
                        end
                    end
                end
                S_FILL: begin
                    if (level_q == LVL_MAX) begin
                        paused_d = 1'b0;
                        if (paused_q && zone_req_i[active_q]) begin
                            state_d = S_IRR;
                            phase_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_IRR: begin
                    // A dropped request wins over the low-level pause.
                    if (!zone_req_i[active_q]) begin
                        state_d     = fert_q ? S_CLEAN : S_IDLE;
                        clean_cnt_d = '0;
                    end else if (level_q <= LVL_LOW) begin
                        state_d  = S_FILL;
                        paused_d = 1'b1;
                    end else if (tick_i) begin
                        phase_d = drip_q ? !phase_q : phase_q;
                        if (!drip_q || phase_q)
                            level_d = level_q - LEVEL_W'(1);
                    end
                end
                S_CLEAN: begin
                    if (tick_i) begin
                        if (clean_cnt_q == CW'(CLEAN_TICKS - 1)) begin
                            state_d = S_IDLE;
                            fert_d  = 1'b0;
                        end else begin
                            clean_cnt_d = clean_cnt_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end

        // Outputs are decoded from next state so they register alongside it.
        valve_in_d   = (state_d == S_IDLE && level_d < LVL_MAX) || state_d == S_FILL || state_d == S_CLEAN;
        zone_valve_d = (state_d == S_IRR || state_d == S_CLEAN) ? (NUM_ZONES'(1) << active_d) : '0;
        cleaning_d   = (state_d == S_CLEAN);
        erro_d       = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            level_q      <= '0;
            active_q     <= '0;
            fert_q       <= 1'b0;
            drip_q       <= 1'b0;
            phase_q      <= 1'b0;
            paused_q     <= 1'b0;
            clean_cnt_q  <= '0;
            timer_q      <= '0;
            valve_in_q   <= 1'b0;
            zone_valve_q <= '0;
            cleaning_q   <= 1'b0;
            erro_q       <= 1'b0;
`ifdef RR_ARB_EN
            last_q       <= AZW'(NUM_ZONES - 1);
`endif
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            active_q     <= active_d;
            fert_q       <= fert_d;
            drip_q       <= drip_d;
            phase_q      <= phase_d;
            paused_q     <= paused_d;
            clean_cnt_q  <= clean_cnt_d;
            timer_q      <= timer_d;
            valve_in_q   <= valve_in_d;
            zone_valve_q <= zone_valve_d;
            cleaning_q   <= cleaning_d;
            erro_q       <= erro_d;
`ifdef RR_ARB_EN
            last_q       <= last_d;
`endif
        end
    end

    assign valve_in_o    = valve_in_q;
    assign zone_valve_o  = zone_valve_q;
    assign level_o       = level_q;
    assign active_zone_o = active_q;
    assign cleaning_o    = cleaning_q;
    assign erro_o        = erro_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_irrigation_zone_controller.sv
// Bench for irrigation_zone_controller: directed scenarios plus random traffic against a tank model.
`timescale 1ns/1ps
module tb_irrigation_zone_controller;

    localparam int N = 4, MAX = 7, LOW = 2, CT = 3, TMO = 4;
    localparam int IDLE = 0, FILL = 1, IRR = 2, CLEAN = 3, ERR = 4;

    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, adb = 1'b0, sup = 1'b1;
    logic [3:0] req = 4'd0, mode = 4'd0;
    logic       valve_in, cleaning, erro;
    logic [3:0] zone_valve;
    logic [2:0] level, state;
    logic [1:0] active_zone;

    int n_tot = 0, n_bad = 0, n_cyc = 0, ps;
    // tank model
    int m_st, m_lvl, m_act, m_last, m_fert, m_drip, m_runticks, m_pause, m_cleanticks, m_dry, m_vin;
    int exp_g[4];

    irrigation_zone_controller dut (
        .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .zone_req_i(req), .zone_mode_i(mode),
        .adb_i(adb), .supply_ok_i(sup), .valve_in_o(valve_in), .zone_valve_o(zone_valve),
        .level_o(level), .active_zone_o(active_zone), .cleaning_o(cleaning), .erro_o(erro),
        .state_o(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, n_cyc, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_st = IDLE; m_lvl = 0; m_act = 0; m_last = N - 1; m_fert = 0; m_drip = 0;
        m_runticks = 0; m_pause = 0; m_cleanticks = 0; m_dry = 0; m_vin = 0;
    endtask

    function automatic int arbitrate(input logic [3:0] r);
`ifdef RR_ARB_EN
        for (int k = 1; k <= N; k++)
            if (r[(m_last + k) % N]) return (m_last + k) % N;
`else
        for (int k = 0; k < N; k++)
            if (r[k]) return k;
`endif
        return 0;
    endfunction

    // One clock of the tank rules, applied to the inputs present before the edge.
    task automatic m_step();
        int nst, nl, g;
        if (m_st == ERR) return;
        if (tick) begin
            if (m_vin == 1 && !sup) begin
                m_dry++;
                if (m_dry == TMO) begin
                    m_st = ERR; m_vin = 0;
                    return;
                end
            end else m_dry = 0;
        end
        nst = m_st; nl = m_lvl;
        if (tick && m_vin == 1 && sup && m_lvl < MAX && (m_st == IDLE || m_st == FILL)) nl = m_lvl + 1;
        if (m_st == IDLE && req != 0) begin
            if (m_lvl > LOW) begin
                g = arbitrate(req);
                nst = IRR; m_act = g; m_last = g; m_fert = adb; m_drip = mode[g] ? 0 : 1; m_runticks = 0;
            end else begin
                nst = FILL; m_pause = 0;
            end
        end else if (m_st == FILL && m_lvl == MAX) begin
            nst = (m_pause == 1 && req[m_act]) ? IRR : IDLE;
            m_runticks = 0; m_pause = 0;
        end else if (m_st == IRR) begin
            if (!req[m_act]) begin
                nst = m_fert ? CLEAN : IDLE; m_cleanticks = 0;
            end else if (m_lvl <= LOW) begin
                nst = FILL; m_pause = 1;
            end else if (tick) begin
                m_runticks++;
                // sprinklers drain every tick, drip every second tick of the run
                if (m_drip == 0 || m_runticks % 2 == 0) nl = m_lvl - 1;
            end
        end else if (m_st == CLEAN && tick) begin
            m_cleanticks++;
            if (m_cleanticks == CT) begin nst = IDLE; m_fert = 0; end
        end
        m_st = nst; m_lvl = nl;
        m_vin = ((m_st == IDLE && m_lvl < MAX) || m_st == FILL || m_st == CLEAN) ? 1 : 0;
    endtask

    task automatic cyc();
        int ezv;
        m_step();
        @(posedge clk);
        @(negedge clk);
        n_cyc++;
        ezv = (m_st == IRR || m_st == CLEAN) ? (1 << m_act) : 0;
        chk("state", 32'(state), 32'(m_st));
        chk("level", 32'(level), 32'(m_lvl));
        chk("valve_in", 32'(valve_in), 32'(m_vin));
        chk("zone_valve", 32'(zone_valve), 32'(ezv));
        chk("active_zone", 32'(active_zone), 32'(m_act));
        chk("cleaning", 32'(cleaning), 32'(m_st == CLEAN));
        chk("erro", 32'(erro), 32'(m_st == ERR));
    endtask

    task automatic pulse(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc(); cyc();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; m_reset();
        req = 4'd0; adb = 1'b0; sup = 1'b1; tick = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cyc(); cyc();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired tot=%0d", n_tot);
        $fatal(1);
    end

    initial begin
`ifdef RR_ARB_EN
        exp_g = '{0, 1, 3, 0};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_valves", 32'({valve_in, zone_valve}), 0);
        chk("rst_flags", 32'({cleaning, erro, active_zone}), 0);
        $display("reset: state=%0d level=%0d", state, level);
        rst_n = 1'b1;
        cyc(); cyc();

        // top-up from empty
        pulse(7);
        chk("fill_level", 32'(level), 7);
        chk("fill_vin", 32'(valve_in), 0);
        chk("fill_state", 32'(state), IDLE);
        $display("topup: level=%0d valve_in=%0d", level, valve_in);

        // sprinkler on zone 1, pause at low level, refill, resume
        req = 4'b0010; mode = 4'b1111; adb = 1'b0; cyc();
        chk("spr_state", 32'(state), IRR);
        chk("spr_zone", 32'(active_zone), 1);
        pulse(5);
        chk("spr_low_level", 32'(level), 2);
        chk("spr_paused", 32'(state), FILL);
        pulse(5);
        chk("spr_resume", 32'(state), IRR);
        chk("spr_resume_lvl", 32'(level), 7);
        req = 4'd0; cyc();
        chk("spr_done", 32'(state), IDLE);
        $display("sprinkler: resumed zone=%0d state=%0d", active_zone, state);

        // drip on zone 2 with fertiliser, then flush
        req = 4'b0100; mode = 4'b0000; adb = 1'b1; cyc();
        adb = 1'b0; mode = 4'b1111;
        pulse(6);
        chk("drip_level", 32'(level), 4);
        req = 4'd0; cyc();
        chk("clean_flag", 32'(cleaning), 1);
        chk("clean_valves", 32'({valve_in, zone_valve}), 32'b10100);
        pulse(2);
        chk("clean_hold", 32'(state), CLEAN);
        pulse(1);
        chk("clean_end", 32'(state), IDLE);
        chk("clean_level", 32'(level), 4);
        $display("drip+clean: level=%0d state=%0d", level, state);

        // arbitration with 1011
        do_reset();
        pulse(4);
        for (int k = 0; k < 4; k++) begin
            req = 4'b1011; mode = 4'($urandom); cyc();
            chk("arb_grant", 32'(active_zone), 32'(exp_g[k]));
            $display("arb: grant %0d -> zone=%0d", k, active_zone);
            req = 4'd0; cyc();
        end

        // supply fault
        do_reset();
        pulse(3);
        sup = 1'b0;
        pulse(3);
        chk("dry_not_yet", 32'(state), IDLE);
        pulse(1);
        chk("err_state", 32'(state), ERR);
        chk("err_flag", 32'(erro), 1);
        chk("err_valves", 32'({valve_in, zone_valve}), 0);
        req = 4'b0001; sup = 1'b1;
        pulse(3);
        chk("err_sticky", 32'(erro), 1);
        chk("err_level", 32'(level), 3);
        $display("fault: state=%0d erro=%0d level=%0d", state, erro, level);

        // asynchronous reset mid-irrigation
        do_reset();
        pulse(5);
        req = 4'b0001; mode = 4'b1111; cyc();
        pulse(1);
        chk("pre_rst_state", 32'(state), IRR);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_out", 32'({valve_in, zone_valve, level, active_zone}), 0);
        m_reset();
        @(posedge clk); @(negedge clk);
        chk("arst_edge", 32'({valve_in, zone_valve, level, cleaning, erro, state}), 0);
        $display("async reset: state=%0d level=%0d", state, level);
        req = 4'd0; rst_n = 1'b1;
        cyc(); cyc();

        // random traffic
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 5) == 0) req = 4'($urandom);
            mode = 4'($urandom);
            adb  = 1'($urandom);
            sup  = ($urandom_range(0, 11) != 0);
            tick = ($urandom_range(0, 2) == 0);
            ps = m_st;
            cyc();
            if (m_st == IRR && ps != IRR)
                $display("rand: grant zone=%0d level=%0d fert=%0d", m_act, m_lvl, m_fert);
        end
        tick = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
